// File: rtl/led_mode_sequencer_if.sv
// Button, speed and LED-bank signals of the LED mode sequencer.
// The board side is the master and the sequencer is the slave.
interface led_mode_sequencer_if;
    logic       BTN_MODE;
    logic       BTN_PAUSE;
    logic [1:0] SPEED;
    logic [7:0] LED;
    logic [1:0] MODE;
    logic       TICK;

    modport master (
        output BTN_MODE, BTN_PAUSE, SPEED,
        input  LED, MODE, TICK
    );

    modport slave (
        input  BTN_MODE, BTN_PAUSE, SPEED,
        output LED, MODE, TICK
    );
endinterface

// File: rtl/led_mode_sequencer.sv
// LED bank sequencer: four display modes stepped by a debounced button, with
// pause and a speed-scaled tick generator.
module led_mode_sequencer #(
    parameter int unsigned DIV_MAX = 10000000,
    parameter int unsigned LOCKOUT = 500000
) (
    input logic                  CLK_IN,
    input logic                  RST_N,
    led_mode_sequencer_if.slave  bus
);

    localparam int unsigned DIV_W = $clog2(DIV_MAX + 1);
    localparam int unsigned LK_W  = $clog2(LOCKOUT + 1);

    typedef enum logic [1:0] {
        ST_UP    = 2'd0,
        ST_DOWN  = 2'd1,
        ST_SCAN  = 2'd2,
        ST_BLINK = 2'd3
    } mode_t;

    mode_t             state, state_next;
    logic [7:0]        led, led_next;
    logic [DIV_W-1:0]  div, div_next;
    logic              tick, tick_next;
    logic              scan_right, scan_right_next;
    logic              paused, paused_next;
    logic [LK_W-1:0]   mode_lock, mode_lock_next;
    logic [LK_W-1:0]   pause_lock, pause_lock_next;
    logic [2:0]        mode_sync, pause_sync;

    logic              mode_press, pause_press;
    logic [31:0]       period, period_m1;
    logic              fire;
    logic [7:0]        scan_shift;

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            state      <= ST_UP;
            led        <= '0;
            div        <= '0;
            tick       <= 1'b0;
            scan_right <= 1'b0;
            paused     <= 1'b0;
            mode_lock  <= '0;
            pause_lock <= '0;
            mode_sync  <= '0;
            pause_sync <= '0;
        end else begin
            state      <= state_next;
            led        <= led_next;
            div        <= div_next;
            tick       <= tick_next;
            scan_right <= scan_right_next;
            paused     <= paused_next;
            mode_lock  <= mode_lock_next;
            pause_lock <= pause_lock_next;
            mode_sync  <= {mode_sync[1:0], bus.BTN_MODE};
            pause_sync <= {pause_sync[1:0], bus.BTN_PAUSE};
        end
    end

    always_comb begin
        state_next      = state;
        led_next        = led;
        div_next        = div;
        tick_next       = 1'b0;
        scan_right_next = scan_right;
        paused_next     = paused;
        mode_lock_next  = mode_lock;
        pause_lock_next = pause_lock;

        // sync[1] is the synchronized level, sync[2] its previous value
        mode_press  = mode_sync[1]  & ~mode_sync[2]  & (mode_lock  == '0);
        pause_press = pause_sync[1] & ~pause_sync[2] & (pause_lock == '0);

        period = DIV_MAX >> bus.SPEED;
        if (period == 32'd0) period = 32'd1;
        period_m1 = period - 32'd1;
        fire = (32'(div) >= period_m1);

        scan_shift = scan_right ? (led >> 1) : (led << 1);

        if (mode_press)           mode_lock_next = LK_W'(LOCKOUT);
        else if (mode_lock != '0) mode_lock_next = mode_lock - 1'b1;
        if (pause_press)           pause_lock_next = LK_W'(LOCKOUT);
        else if (pause_lock != '0) pause_lock_next = pause_lock - 1'b1;

        if (pause_press) paused_next = ~paused;

        if (mode_press) begin
            div_next        = '0;
            scan_right_next = 1'b0;
            case (state)
                ST_UP:    begin state_next = ST_DOWN;  led_next = 8'hFF; end
                ST_DOWN:  begin state_next = ST_SCAN;  led_next = 8'h01; end
                ST_SCAN:  begin state_next = ST_BLINK; led_next = 8'h00; end
                default:  begin state_next = ST_UP;    led_next = 8'h00; end
            endcase
        end else if (!paused) begin
            if (fire) begin
                div_next  = '0;
                tick_next = 1'b1;
                case (state)
                    ST_UP:   led_next = led + 8'd1;
                    ST_DOWN: led_next = led - 8'd1;
                    ST_SCAN: begin
                        led_next = scan_shift;
                        if (scan_shift == 8'h80) scan_right_next = 1'b1;
                        if (scan_shift == 8'h01) scan_right_next = 1'b0;
                    end
                    default: led_next = ~led;
                endcase
            end else begin
                div_next = div + 1'b1;
            end
        end
    end

    assign bus.LED  = led;
    assign bus.MODE = state;
    assign bus.TICK = tick;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Randomized and directed stimulus for led_mode_sequencer, checked every cycle
// against a behavioural model built from the display-mode rules.
module tb_led_mode_sequencer;

    localparam int DIV_MAX = 8;
    localparam int LOCKOUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_mode_sequencer_if bus ();

    led_mode_sequencer #(.DIV_MAX(DIV_MAX), .LOCKOUT(LOCKOUT)) dut (
        .CLK_IN (clk),
        .RST_N  (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // model state: values the DUT should show after the most recent edge
    int m_mode, m_led, m_cnt, m_pos, m_lock_m, m_lock_p;
    bit m_paused, m_tick;
    bit hm[3];
    bit hp[3];
    bit [1:0] spd_r = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int entry_led(input int mode);
        case (mode)
            1:       return 8'hFF;
            2:       return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    // SCAN as a 14-position bounce: positions 0..7 climb, 8..13 descend
    function automatic int scan_led(input int pos);
        return (pos < 8) ? (1 << pos) : (1 << (14 - pos));
    endfunction

    task automatic model_reset();
        m_mode = 0; m_led = 0; m_cnt = 0; m_pos = 0;
        m_lock_m = 0; m_lock_p = 0; m_paused = 0; m_tick = 0;
        for (int i = 0; i < 3; i++) begin hm[i] = 0; hp[i] = 0; end
    endtask

    task automatic model_edge(input bit bm, input bit bp, input bit [1:0] spd, input bit rn);
        bit mp, pp;
        int p;
        if (!rn) begin
            model_reset();
            return;
        end
        mp = hm[1] && !hm[2] && (m_lock_m == 0);
        pp = hp[1] && !hp[2] && (m_lock_p == 0);
        p = DIV_MAX >> spd;
        if (p < 1) p = 1;
        if (mp) m_lock_m = LOCKOUT; else if (m_lock_m > 0) m_lock_m--;
        if (pp) m_lock_p = LOCKOUT; else if (m_lock_p > 0) m_lock_p--;
        if (mp) begin
            m_mode = (m_mode + 1) % 4;
            m_led  = entry_led(m_mode);
            m_pos  = 0;
            m_cnt  = 0;
            m_tick = 0;
        end else if (m_paused) begin
            m_tick = 0;
        end else if (m_cnt >= p - 1) begin
            m_cnt  = 0;
            m_tick = 1;
            case (m_mode)
                0: m_led = (m_led + 1) % 256;
                1: m_led = (m_led + 255) % 256;
                2: begin m_pos = (m_pos + 1) % 14; m_led = scan_led(m_pos); end
                default: m_led = 255 - m_led;
            endcase
        end else begin
            m_cnt++;
            m_tick = 0;
        end
        if (pp) m_paused = !m_paused;
        hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = bm;
        hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = bp;
    endtask

    // compare outputs of the last edge, then drive and predict the next edge
    task automatic step(input bit bm, input bit bp, input bit [1:0] spd, input bit rn);
        @(negedge clk);
        check("LED", {24'd0, bus.LED}, m_led);
        check("MODE", {30'd0, bus.MODE}, m_mode);
        check("TICK", {31'd0, bus.TICK}, m_tick);
        bus.BTN_MODE  = bm;
        bus.BTN_PAUSE = bp;
        bus.SPEED     = spd;
        rst_n         = rn;
        spd_r         = spd;
        model_edge(bm, bp, spd, rn);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, spd_r, 1'b1);
    endtask

    // two-cycle press; returns just after the edge that acts on it
    task automatic press(input bit m, input bit p);
        run(LOCKOUT);
        step(m, p, spd_r, 1'b1);
        step(m, p, spd_r, 1'b1);
        step(1'b0, 1'b0, spd_r, 1'b1);
        step(1'b0, 1'b0, spd_r, 1'b1);
    endtask

    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        while (m_cnt != target && n < 100) begin
            run(1);
            n++;
        end
        if (n >= 100) check("wait_cnt_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_mode, held, n;
        bit rb_m, rb_p;

        bus.BTN_MODE = 1'b0;
        bus.BTN_PAUSE = 1'b0;
        bus.SPEED = 2'd0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        check("reset_led", {24'd0, bus.LED}, 0);

        // UP count through a full wrap
        run(DIV_MAX * 257 + 3);

        // mode stepping, including a SCAN bounce run
        press(1'b1, 1'b0);
        check("step_mode1", {30'd0, bus.MODE}, 1);
        check("step_led_ff", {24'd0, bus.LED}, 8'hFF);
        press(1'b1, 1'b0);
        check("step_mode2", {30'd0, bus.MODE}, 2);
        check("step_led_01", {24'd0, bus.LED}, 8'h01);
        run(DIV_MAX * 16 + 2);
        press(1'b1, 1'b0);
        check("step_mode3", {30'd0, bus.MODE}, 3);
        run(DIV_MAX * 3);
        press(1'b1, 1'b0);
        check("step_mode0", {30'd0, bus.MODE}, 0);
        check("step_led_00", {24'd0, bus.LED}, 0);

        // bounce within lockout gives one step only
        run(LOCKOUT);
        step(1'b1, 1'b0, spd_r, 1'b1);
        step(1'b0, 1'b0, spd_r, 1'b1);
        step(1'b1, 1'b0, spd_r, 1'b1);
        run(3);
        check("debounce_one", {30'd0, bus.MODE}, 1);
        press(1'b1, 1'b0);
        check("debounce_again", {30'd0, bus.MODE}, 2);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);

        // pause at LED=05
        n = 0;
        while (m_led != 5 && n < 200) begin run(1); n++; end
        if (n >= 200) check("wait_led5_timeout", 0, 1);
        press(1'b0, 1'b1);
        run(50);
        check("pause_hold", {24'd0, bus.LED}, 5);
        check("pause_tick", {31'd0, bus.TICK}, 0);
        spd_r = 2'd3;
        press(1'b0, 1'b1);
        run(8);
        spd_r = 2'd0;
        run(1);
        wait_cnt(6);
        step(1'b0, 1'b0, 2'd1, 1'b1);
        run(12);

        // mode press landing on the tick edge
        spd_r = 2'd0;
        run(LOCKOUT);
        wait_cnt(5);
        prev_mode = m_mode;
        step(1'b1, 1'b0, spd_r, 1'b1);
        step(1'b1, 1'b0, spd_r, 1'b1);
        step(1'b0, 1'b0, spd_r, 1'b1);
        step(1'b0, 1'b0, spd_r, 1'b1);
        check("collide_tick", {31'd0, bus.TICK}, 0);
        check("collide_led", {24'd0, bus.LED}, entry_led((prev_mode + 1) % 4));

        // both buttons in the same cycle
        prev_mode = m_mode;
        press(1'b1, 1'b1);
        check("both_mode", {30'd0, bus.MODE}, (prev_mode + 1) % 4);
        held = entry_led((prev_mode + 1) % 4);
        run(20);
        check("both_paused", {24'd0, bus.LED}, held);
        press(1'b0, 1'b1);
        run(30);

        // reset mid-sequence
        step(1'b0, 1'b0, spd_r, 1'b0);
        step(1'b0, 1'b0, spd_r, 1'b1);
        check("rst_led", {24'd0, bus.LED}, 0);
        check("rst_mode", {30'd0, bus.MODE}, 0);
        check("rst_tick", {31'd0, bus.TICK}, 0);

        // random traffic
        rb_m = 0; rb_p = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(99) < 4)  rb_m = ~rb_m;
            if ($urandom_range(99) < 3)  rb_p = ~rb_p;
            if ($urandom_range(199) < 2) spd_r = 2'($urandom_range(3));
            step(rb_m, rb_p, spd_r, ($urandom_range(999) < 2) ? 1'b0 : 1'b1);
        end
        run(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_mode_sequencer.md
# led_mode_sequencer

Controller for the 8-bit LED bank of the Spartan-3E starter board. It sequences the LED datapath through four display modes from one internal tick generator, and replaces the fixed free-running divide-and-increment counter. Two board push-buttons step the mode and pause/resume the sequence. A 2-bit speed select scales the tick rate.

## Interface
- DIV_MAX, 10000000: base tick period in CLK_IN cycles, for SPEED=0. Must be ≥ 8.
- LOCKOUT, 500000: button debounce lockout, in CLK_IN cycles.
- CLK_IN  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  reset, synchronous and active-low.
- BTN_MODE  in  1  raw push-button, asynchronous, active-high; steps the mode.
- BTN_PAUSE  in  1  raw push-button, asynchronous, active-high; toggles pause.
- SPEED  in  2  tick rate select; period = max(1, DIV_MAX >> SPEED).
- LED  out  8  LED bank drive.
- MODE  out  2  current mode: 0=UP, 1=DOWN, 2=SCAN, 3=BLINK.
- TICK  out  1  one-cycle pulse on each pattern step.

## Operation
- **Reset** (RST_N=0 at an edge):
  - LED=8'h00, MODE=0, TICK=0.
  - paused=0, divider=0, both lockout counters=0, all synchronizer flops=0.
- **Button path** (each button independently):
  - 2-flop synchronizer, then a third flop for edge detection.
  - A press is a synced 0→1 edge while that button's lockout counter is 0.
  - An accepted press loads the lockout counter with LOCKOUT; it decrements to 0.
  - Edges seen while the counter is non-zero are discarded.
- **Mode FSM** (UP→DOWN→SCAN→BLINK→UP, one step per accepted BTN_MODE press). On entry to a state:
  - LED is loaded: UP 8'h00, DOWN 8'hFF, SCAN 8'h01 with direction=left, BLINK 8'h00.
  - divider is cleared.
- **Step on TICK**, by mode:
  - UP: LED+1, wrapping FF→00.
  - DOWN: LED−1, wrapping 00→FF.
  - SCAN: shift toward the current direction. The direction reverses after LED reaches 8'h80 (now moving right) or 8'h01 (now moving left). The sequence is 01,02,…,80,40,…,01,02,… with a 14-tick cycle and no repeated endpoint.
  - BLINK: LED toggles between 00 and FF.
- **Pause**:
  - An accepted BTN_PAUSE press toggles paused.
  - While paused, divider and LED hold and TICK=0.
  - A mode change while paused still loads the entry LED value and clears the divider; paused stays set.
- **Simultaneous events**:
  - Accepted MODE and PAUSE presses in the same cycle both take effect.
  - A mode change takes priority over a coincident tick: the entry value is loaded, divider is cleared, and TICK is suppressed that cycle.
- **SPEED change** takes effect immediately; nothing is latched.

## Timing
- **Divider**:
  - Increments each unpaused cycle.
  - When divider ≥ period−1, the next edge sets divider=0, asserts TICK for exactly one cycle, and applies the LED step.
  - The LED change and the TICK high level appear after the same edge.
  - The ≥ comparison prevents overrun when SPEED shortens the period mid-count.
- **Tick spacing**: in steady state, TICK pulses are exactly `period` cycles apart. For SPEED=0 the first tick after reset or a mode change follows DIV_MAX edges.
- **Button latency**: a button first sampled high at edge k (sync stage 1) is acted on at edge k+2. MODE/LED/paused are updated after edge k+2.
- **Lockout**: the lockout counter is loaded at edge k+2. A new edge is accepted no earlier than LOCKOUT cycles later.
- **Reset mid-operation**: all state returns to reset values on the first edge with RST_N=0. Pending presses and lockouts are discarded.

## Test plan
All directed tests use DIV_MAX=8 and LOCKOUT=4.
- **Reset and UP count**: release reset, SPEED=0 → TICK every 8 cycles. LED goes 00,01,02,… and after 256 ticks wraps FF→00. MODE=0.
- **Mode stepping**: hold BTN_MODE high for 2 cycles →
  - MODE=1 and LED=FF, two edges after the first sampled-high edge.
  - Further presses give MODE=2 with LED=01, then MODE=3 with LED=00, then MODE=0 with LED=00.
- **SCAN bounce**: in mode 2, run 16 ticks → LED sequence 02,04,…,80,40,20,…,01,02,04.
- **Debounce**: in mode 0, pulse BTN_MODE high for 1 cycle, low for 1 cycle, high for 1 cycle → exactly one mode step (MODE=1). A pulse after ≥4 idle cycles steps again (MODE=2).
- **Pause and speed**: pause in UP at LED=05 → LED holds and TICK stays 0 for 50 cycles. Resume with SPEED=3 → ticks every 1 cycle. Set SPEED=1 when divider=6 → the tick fires on the next edge, then every 4 cycles.
- **Collisions and reset**:
  - Mode press landing on the tick edge → entry value loaded and no TICK that cycle.
  - Both buttons accepted in the same cycle → MODE advances and paused=1.
  - RST_N=0 for one cycle mid-sequence → LED=00, MODE=0, TICK=0 on the next cycle.
